nextion_tx_sched: RTL and testbench
===================================

Name: nextion_tx_sched

Overview:
- Message scheduler sitting between ADC-side producers and the byte-level UART transmitter.
- Arbitrates two requesters:
  - waveform point: Nextion "add" command
  - numeric readout: Nextion "n<obj>.val=" command
- Formats the captured value as decimal ASCII, then streams the frame one byte at a time under the transmitter's start/busy handshake.
- Each frame ends with the FF FF FF terminator and an optional 0A.

Parameters:
- WAVE_ID, 1, waveform component id; single ASCII digit, 0-9.
- WAVE_CH, 0, waveform channel; 0-3.
- NUM_OBJ, 0, number object index; 0-9.
- TERM_NL, 0, 1 = append 8'h0A after FF FF FF.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- RST_n  input  1  reset, synchronous, active-low.
- req_wave  input  1  level request: send a waveform point.
- wave_val  input  8  point value; sampled on the ack_wave cycle.
- ack_wave  output  1  one-cycle pulse: wave_val captured.
- req_num  input  1  level request: send a numeric readout.
- num_val  input  16  readout value; sampled on the ack_num cycle.
- ack_num  output  1  one-cycle pulse: num_val captured.
- tx_data  output  8  byte presented to the UART transmitter.
- tx_start  output  1  one-cycle pulse: transmitter loads tx_data.
- tx_busy  input  1  transmitter busy; high from the cycle after tx_start until the byte is shifted out.
- busy  output  1  high from ack through the frame_done cycle.
- frame_done  output  1  one-cycle pulse after the last byte completes.

Behaviour:
- Reset (RST_n low at a rising edge):
  - state = IDLE; rr pointer = wave.
  - All outputs 0, including tx_data = 8'h00.
  - Any frame in progress is abandoned; no further tx_start is issued.
  - The byte already started in the transmitter is not recalled.
- States: IDLE -> GRANT -> CONV -> SEND -> WAIT_HI -> WAIT_LO -> (SEND | DONE) -> IDLE.
- IDLE:
  - If either request is high, go to GRANT.
  - If both are high, grant the requester indicated by rr.
- GRANT:
  - Pulse the matching ack for exactly one cycle; latch the value.
  - Select the template; toggle rr to the other requester.
  - A requester that stays high is served again only after the other has had its turn, if the other is pending.
- CONV: binary-to-decimal by repeated subtraction.
  - Powers of ten: 10000, 1000, 100, 10, 1 for num; 100, 10, 1 for wave.
  - At most one subtraction per cycle.
  - Leading zeros suppressed; value 0 yields the single digit "0".
  - Digit count 1-3 (wave) or 1-5 (num).
  - Maximum CONV duration: 50 cycles.
- Frame byte sequences:
  - wave: "add " + WAVE_ID digit + "," + WAVE_CH digit + "," + digits + FF FF FF [+ 0A].
  - num: "n" + NUM_OBJ digit + ".val=" + digits + FF FF FF [+ 0A].
  - Length: wave 12-14 bytes, num 11-15 bytes, plus 1 if TERM_NL.
- SEND:
  - When tx_busy is low: drive tx_data and pulse tx_start for one cycle, then go to WAIT_HI.
  - tx_data holds stable from the tx_start cycle until the next tx_start.
- WAIT_HI: wait for tx_busy = 1, then go to WAIT_LO.
- WAIT_LO: on tx_busy = 0, advance the byte index.
  - More bytes remaining: go to SEND. Next tx_start is no earlier than 1 cycle after busy falls.
  - Last byte done: go to DONE.
- DONE: pulse frame_done; busy drops the following cycle.
- Requests during busy:
  - Not acknowledged.
  - Remain pending if held high.
  - Requests deasserted before ack are dropped; no queueing.
- Simultaneous events:
  - req and frame end on the same cycle: the request is granted from IDLE on the next cycle.
  - Minimum gap between frames: 2 cycles (DONE, IDLE).
- tx_busy high while in IDLE/GRANT/CONV: SEND waits for it to go low.

Test Plan:
- req_wave=1, wave_val=100; tx_busy models 10-cycle bytes -> ack_wave once; bytes 61 64 64 20 31 2C 30 2C 31 30 30 FF FF FF; frame_done once; busy low afterwards.
- req_num, num_val=0, then num_val=65535 -> "n0.val=0" FF FF FF; then "n0.val=65535" FF FF FF; no leading zeros.
- req_wave and req_num high together for 3 frames, starting from reset:
  - Frame order: wave, num, wave.
  - Acks alternate; each ack is exactly 1 cycle.
- TERM_NL=1, WAVE_ID=2, WAVE_CH=3, wave_val=7 -> "add 2,3,7" FF FF FF 0A; 13 tx_start pulses total.
- RST_n low after the 5th tx_start of a num frame:
  - Next cycle: all outputs 0; no further tx_start.
  - After release with req_wave high: a fresh wave frame is sent from byte 0.
- tx_busy stretched to 200 cycles on the 3rd byte:
  - No tx_start while busy is high; tx_data stable.
  - Remaining bytes resume in order.

Source files
------------

// File: rtl/nextion_tx_sched.sv
// Nextion message scheduler: arbitrates waveform/readout requests, formats
// the value as decimal ASCII and streams the frame to the UART transmitter.
module nextion_tx_sched #(
    parameter int WAVE_ID = 1,
    parameter int WAVE_CH = 0,
    parameter int NUM_OBJ = 0,
    parameter bit TERM_NL = 1'b0
) (
    input  logic        clk,
    input  logic        RST_n,
    input  logic        req_wave,
    input  logic [7:0]  wave_val,
    output logic        ack_wave,
    input  logic        req_num,
    input  logic [15:0] num_val,
    output logic        ack_num,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANT   = 3'd1;
    localparam logic [2:0] S_CONV    = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;
    localparam logic [2:0] S_WAIT_LO = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [7:0] WID = 8'(48 + WAVE_ID);
    localparam logic [7:0] WCH = 8'(48 + WAVE_CH);
    localparam logic [7:0] NOB = 8'(48 + NUM_OBJ);
    localparam logic [7:0][7:0] WPRE = {",", WCH, ",", WID, " ", "d", "d", "a"};
    localparam logic [7:0][7:0] NPRE = {8'h00, "=", "l", "a", "v", ".", NOB, "n"};
    localparam logic [4:0] TAIL = TERM_NL ? 5'd3 : 5'd2;

    logic [2:0]       state;
    logic             rr;
    logic             sel_num;
    logic [15:0]      val;
    logic [2:0]       pidx;
    logic [3:0]       cur;
    logic [4:0][3:0]  dig;
    logic [2:0]       ndig;
    logic [4:0]       idx;
    logic [4:0]       pre_len;
    logic [4:0]       dig_end;
    logic [4:0]       ff_end;
    logic [4:0]       last_idx;
    logic [2:0]       doff;
    logic [15:0]      pow;
    logic [7:0]       byte_nx;
    logic             in_pre;
    logic             in_dig;
    logic             in_ff;
    logic             in_nl;

    always_comb begin
        pow = 16'd1;
        unique case (pidx)
            3'd0:    pow = 16'd10000;
            3'd1:    pow = 16'd1000;
            3'd2:    pow = 16'd100;
            3'd3:    pow = 16'd10;
            default: pow = 16'd1;
        endcase
    end

    // Frame layout: prefix, digits, FF FF FF, optional newline.
    always_comb begin
        pre_len  = sel_num ? 5'd7 : 5'd8;
        dig_end  = pre_len + {2'b00, ndig};
        ff_end   = dig_end + 5'd3;
        last_idx = dig_end + TAIL;
        doff     = 3'(idx - pre_len);
        in_pre   = idx < pre_len;
        in_dig   = !in_pre && idx < dig_end;
        in_ff    = !in_pre && !in_dig && idx < ff_end;
        in_nl    = !in_pre && !in_dig && !in_ff;
        byte_nx  = 8'h0A;
        unique case (1'b1)
            in_pre:  byte_nx = sel_num ? NPRE[idx[2:0]] : WPRE[idx[2:0]];
            in_dig:  byte_nx = {4'h3, dig[doff]};
            in_ff:   byte_nx = 8'hFF;
            in_nl:   byte_nx = 8'h0A;
            default: byte_nx = 8'h0A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST_n) begin
            state    <= S_IDLE;
            rr       <= 1'b0;
            sel_num  <= 1'b0;
            val      <= '0;
            pidx     <= '0;
            cur      <= '0;
            dig      <= '0;
            ndig     <= '0;
            idx      <= '0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req_wave || req_num) begin
                        sel_num <= req_num && (!req_wave || rr);
                        state   <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    val   <= sel_num ? num_val : {8'h00, wave_val};
                    rr    <= !sel_num;
                    pidx  <= sel_num ? 3'd0 : 3'd2;
                    cur   <= '0;
                    ndig  <= '0;
                    idx   <= '0;
                    state <= S_CONV;
                end
                S_CONV: begin
                    if (val >= pow) begin
                        val <= val - pow;
                        cur <= cur + 4'd1;
                    end else begin
                        // Units digit is always emitted so 0 gives "0".
                        if (cur != 4'd0 || ndig != 3'd0 || pidx == 3'd4) begin
                            dig[ndig] <= cur;
                            ndig      <= ndig + 3'd1;
                        end
                        cur <= '0;
                        if (pidx == 3'd4) state <= S_SEND;
                        else pidx <= pidx + 3'd1;
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_data  <= byte_nx;
                        tx_start <= 1'b1;
                        state    <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (tx_busy) state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (idx == last_idx) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= S_SEND;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ack_wave   = (state == S_GRANT) && !sel_num;
    assign ack_num    = (state == S_GRANT) && sel_num;
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE);

endmodule

// File: tb/tb_nextion_tx_sched.sv
// Directed bench for nextion_tx_sched: frame content, arbitration,
// reset abort, newline terminator and stretched transmitter busy.
module tb_nextion_tx_sched;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        bit          isnum;
        logic [15:0] val;
        string       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        RST_n = 1'b0;
    logic        req_wave = 1'b0;
    logic [7:0]  wave_val = 8'h00;
    logic        req_num = 1'b0;
    logic [15:0] num_val = 16'h0000;
    logic        ack_wave, ack_num, tx_start, busy, frame_done;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;

    logic        req_wave2 = 1'b0;
    logic [7:0]  wave_val2 = 8'h00;
    logic        ack_wave2, ack_num2, tx_start2, busy2, frame_done2;
    logic [7:0]  tx_data2;
    logic        tx_busy2 = 1'b0;

    always #5 clk = ~clk;

    nextion_tx_sched u_dut (
        .clk(clk), .RST_n(RST_n),
        .req_wave(req_wave), .wave_val(wave_val), .ack_wave(ack_wave),
        .req_num(req_num), .num_val(num_val), .ack_num(ack_num),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .busy(busy), .frame_done(frame_done)
    );

    nextion_tx_sched #(.WAVE_ID(2), .WAVE_CH(3), .NUM_OBJ(0), .TERM_NL(1'b1)) u_dut2 (
        .clk(clk), .RST_n(RST_n),
        .req_wave(req_wave2), .wave_val(wave_val2), .ack_wave(ack_wave2),
        .req_num(1'b0), .num_val(16'h0000), .ack_num(ack_num2),
        .tx_data(tx_data2), .tx_start(tx_start2), .tx_busy(tx_busy2),
        .busy(busy2), .frame_done(frame_done2)
    );

    // Transmitter models: busy for 10 cycles per byte (or 200 when stretched).
    bq_t q, q2;
    int  cnt = 0, cnt2 = 0, stretch_at = -1;

    always @(posedge clk) begin
        if (tx_start) begin
            tx_busy <= 1'b1;
            cnt     <= (q.size() == stretch_at) ? 199 : 9;
            q.push_back(tx_data);
        end else if (cnt > 0) cnt <= cnt - 1;
        else tx_busy <= 1'b0;
    end

    always @(posedge clk) begin
        if (tx_start2) begin
            tx_busy2 <= 1'b1;
            cnt2     <= 9;
            q2.push_back(tx_data2);
        end else if (cnt2 > 0) cnt2 <= cnt2 - 1;
        else tx_busy2 <= 1'b0;
    end

    int    n_cmp = 0, n_bad = 0, viol = 0;
    int    acks_w = 0, acks_n = 0, dones = 0, starts = 0, starts2 = 0;
    string order = "";
    logic  prev_aw = 1'b0, prev_an = 1'b0;
    logic [7:0] last_d = 8'h00;

    always @(negedge clk) begin
        if (ack_wave) begin acks_w++; order = {order, "W"}; end
        if (ack_num)  begin acks_n++; order = {order, "N"}; end
        if ((ack_wave && prev_aw) || (ack_num && prev_an) || (ack_wave && ack_num)) viol++;
        prev_aw = ack_wave;
        prev_an = ack_num;
        if (frame_done) dones++;
        if (tx_start) starts++;
        if (tx_start2) starts2++;
        if (tx_start && tx_busy) viol++;
        if (!RST_n) last_d = 8'h00;
        else if (tx_start) last_d = tx_data;
        else if (tx_data !== last_d) viol++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic string hx(input bq_t b);
        string s = "";
        foreach (b[i]) s = {s, $sformatf("%02h ", b[i])};
        return s;
    endfunction

    task automatic mk_exp(input string s, input bit nl, output bq_t e);
        e = {};
        for (int i = 0; i < s.len(); i++) e.push_back(s[i]);
        for (int i = 0; i < 3; i++) e.push_back(8'hFF);
        if (nl) e.push_back(8'h0A);
    endtask

    task automatic chk_bytes(input string nm, input bq_t act, input bq_t exp);
        bit bad = (act.size() != exp.size());
        if (!bad) foreach (exp[i]) if (act[i] !== exp[i]) bad = 1'b1;
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s bytes: got [%s] want [%s]", nm, hx(act), hx(exp));
        end
    endtask

    task automatic run_frame(input bit isnum, input logic [15:0] v,
                             input string s, input string nm);
        bq_t e;
        int  n;
        q.delete();
        acks_w = 0;
        acks_n = 0;
        dones  = 0;
        if (isnum) begin num_val = v; req_num = 1'b1; end
        else begin wave_val = v[7:0]; req_wave = 1'b1; end
        n = 0;
        while (!(ack_wave || ack_num) && n < 50) begin tick(); n++; end
        req_wave = 1'b0;
        req_num  = 1'b0;
        n = 0;
        while (!frame_done && n < 20000) begin tick(); n++; end
        tick();
        tick();
        mk_exp(s, 1'b0, e);
        chk_bytes(nm, q, e);
        chk({nm, " ack"}, isnum ? acks_n : acks_w, 1);
        chk({nm, " other ack"}, isnum ? acks_w : acks_n, 0);
        chk({nm, " frame_done"}, dones, 1);
        chk({nm, " busy after"}, int'(busy), 0);
    endtask

    vec_t vt[8];

    initial begin
        bq_t e, e2;
        int  n, s0;

        vt[0] = '{1'b0, 16'd100,   "add 1,0,100"};
        vt[1] = '{1'b1, 16'd0,     "n0.val=0"};
        vt[2] = '{1'b1, 16'd65535, "n0.val=65535"};
        vt[3] = '{1'b0, 16'd0,     "add 1,0,0"};
        vt[4] = '{1'b0, 16'd255,   "add 1,0,255"};
        vt[5] = '{1'b1, 16'd9,     "n0.val=9"};
        vt[6] = '{1'b1, 16'd10000, "n0.val=10000"};
        vt[7] = '{1'b1, 16'd1005,  "n0.val=1005"};

        repeat (3) tick();
        chk("reset outputs", int'({ack_wave, ack_num, tx_start, busy, frame_done, tx_data}), 0);
        chk("reset outputs dut2", int'({ack_wave2, ack_num2, tx_start2, busy2, frame_done2, tx_data2}), 0);

        // Both requesters held high from reset: wave, num, wave.
        RST_n = 1'b1;
        q.delete();
        order  = "";
        acks_w = 0;
        acks_n = 0;
        dones  = 0;
        wave_val = 8'd5;
        num_val  = 16'd42;
        req_wave = 1'b1;
        req_num  = 1'b1;
        n = 0;
        while (dones < 3 && n < 5000) begin tick(); n++; end
        req_wave = 1'b0;
        req_num  = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (order != "WNW") begin
            n_bad++;
            $display("FAIL arb order: got %s want WNW", order);
        end
        chk("arb wave acks", acks_w, 2);
        chk("arb num acks", acks_n, 1);
        mk_exp("add 1,0,5", 1'b0, e);
        mk_exp("n0.val=42", 1'b0, e2);
        e = {e, e2};
        mk_exp("add 1,0,5", 1'b0, e2);
        e = {e, e2};
        chk_bytes("arb", q, e);

        for (int i = 0; i < 8; i++)
            run_frame(vt[i].isnum, vt[i].val, vt[i].exp, $sformatf("vec%0d", i));

        // Newline-terminated frame on the second instance.
        q2.delete();
        starts2   = 0;
        wave_val2 = 8'd7;
        req_wave2 = 1'b1;
        n = 0;
        while (!ack_wave2 && n < 50) begin tick(); n++; end
        req_wave2 = 1'b0;
        n = 0;
        while (!frame_done2 && n < 5000) begin tick(); n++; end
        tick();
        mk_exp("add 2,3,7", 1'b1, e);
        chk_bytes("term_nl", q2, e);
        chk("term_nl starts", starts2, 13);

        // Reset after the 5th byte of a num frame.
        q.delete();
        num_val = 16'd1234;
        req_num = 1'b1;
        n = 0;
        while (q.size() < 5 && n < 2000) begin tick(); n++; end
        chk("abort reached 5th byte", q.size(), 5);
        req_num = 1'b0;
        RST_n   = 1'b0;
        tick();
        chk("abort outputs", int'({ack_wave, ack_num, tx_start, busy, frame_done, tx_data}), 0);
        s0 = starts;
        tick();
        tick();
        chk("abort no start in reset", starts - s0, 0);
        q.delete();
        acks_w = 0;
        dones  = 0;
        wave_val = 8'd3;
        req_wave = 1'b1;
        RST_n    = 1'b1;
        n = 0;
        while (!ack_wave && n < 50) begin tick(); n++; end
        req_wave = 1'b0;
        n = 0;
        while (!frame_done && n < 5000) begin tick(); n++; end
        tick();
        mk_exp("add 1,0,3", 1'b0, e);
        chk_bytes("after abort", q, e);
        chk("after abort acks", acks_w, 1);

        // 200-cycle busy on the 3rd byte.
        stretch_at = 2;
        n = $time;
        run_frame(1'b1, 16'd321, "n0.val=321", "stretch");
        chk("stretch took long", int'(($time - n) > 2000), 1);
        stretch_at = -1;

        chk("protocol violations", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
